// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store sequencer driving a req/gnt/rvalid data port.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   mem_valid_i, mem_we_i     MEM stage access present / store select
//   funct3M, addr_i, wdata_i  access size/sign, byte address, store data
//   stall_o                   holds IF..MEM while an access is outstanding
//   dmem_req_o/we_o/addr_o/be_o/wdata_o   registered memory request
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i  memory responses
//   load_valid_o, load_data_o  load completion pulse and extended result
//   access_err_o               pulse on misalignment, illegal funct3 or timeout
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3M,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        access_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t state, state_nx;
  logic we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [31:0] cnt;
  logic legal, accept, tmo;
  logic [3:0] be_nx;
  logic [31:0] wdata_nx, ext;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  always_comb begin
    legal = !(funct3M == 3'b011 || funct3M[2:1] == 2'b11 || (mem_we_i && funct3M[2])
              || (funct3M[1:0] == 2'b01 && addr_i[0]) || (funct3M[1:0] == 2'b10 && addr_i[1:0] != 2'b00));
    accept = state == IDLE && mem_valid_i && legal;
    tmo = TIMEOUT_CYCLES != 0 && cnt == TMO_LAST;
    stall_o = accept || state == REQ || state == WAIT;
    be_nx = funct3M[1:0] == 2'b00 ? 4'b0001 << addr_i[1:0] :
            funct3M[1:0] == 2'b01 ? 4'b0011 << addr_i[1:0] : 4'b1111;
    wdata_nx = funct3M[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
               funct3M[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    byte_sel = dmem_rdata_i[8*off_q +: 8];
    half_sel = dmem_rdata_i[16*off_q[1] +: 16];
    ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_sel[7]}}, byte_sel} :
          f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_sel[15]}}, half_sel} : dmem_rdata_i;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? REQ : IDLE;
      REQ:  state_nx = dmem_gnt_i ? (we_q ? DONE : WAIT) : (tmo ? DONE : REQ);
      WAIT: state_nx = (dmem_rvalid_i || tmo) ? DONE : WAIT;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      f3_q <= 3'b000;
      off_q <= 2'b00;
      cnt <= '0;
      dmem_req_o <= 1'b0;
      dmem_we_o <= 1'b0;
      dmem_addr_o <= '0;
      dmem_be_o <= '0;
      dmem_wdata_o <= '0;
      load_valid_o <= 1'b0;
      load_data_o <= '0;
      access_err_o <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      access_err_o <= 1'b0;
      if (state == IDLE && mem_valid_i && !legal) access_err_o <= 1'b1;
      if (accept) begin
        we_q <= mem_we_i;
        f3_q <= funct3M;
        off_q <= addr_i[1:0];
        cnt <= '0;
        dmem_req_o <= 1'b1;
        dmem_we_o <= mem_we_i;
        dmem_addr_o <= {addr_i[31:2], 2'b00};
        dmem_be_o <= be_nx;
        dmem_wdata_o <= wdata_nx;
      end
      if (state == REQ || state == WAIT) cnt <= cnt + 1'b1;
      if (state == REQ && (dmem_gnt_i || tmo)) dmem_req_o <= 1'b0;
      // rvalid wins over a timeout that expires in the same cycle
      if ((state == REQ && !dmem_gnt_i && tmo) || (state == WAIT && !dmem_rvalid_i && tmo)) access_err_o <= 1'b1;
      if (state == WAIT && dmem_rvalid_i) begin
        load_data_o <= ext;
        load_valid_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with directed load/store vectors.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_valid_i = 1'b0, mem_we_i = 1'b0;
  logic [2:0] funct3M = 3'b000;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0] dmem_be_o;
  logic dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic load_valid_o, access_err_o;
  logic [31:0] load_data_o;
  always #5 clk = ~clk;
  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i),
    .funct3M(funct3M), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .load_valid_o(load_valid_o), .load_data_o(load_data_o), .access_err_o(access_err_o)
  );
  typedef struct {
    int kind;
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0] be;
    logic we;
  } ev_t;
  localparam int K_REQ = 0, K_LOAD = 1, K_ERR = 2, K_STALL = 3;
  ev_t q[$];
  int ncmp = 0, nfail = 0;
  int gnt_wait = 0, age = 0, run_len = 0;
  bit manual = 1'b0;
  logic pend = 1'b0, prev_req = 1'b0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic push(input int k, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be, input logic we);
    ev_t e;
    e.kind = k; e.a = a; e.w = w; e.be = be; e.we = we;
    q.push_back(e);
  endtask
  task automatic observe(input int k, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be, input logic we);
    ev_t e;
    if (q.size() == 0) begin
      ncmp++;
      nfail++;
      $display("FAIL unexpected event: got kind %0d value %h, nothing expected", k, a);
      return;
    end
    e = q.pop_front();
    chk("event kind", k, e.kind);
    if (k != e.kind) return;
    if (k == K_REQ) begin
      chk("dmem_addr", a, e.a);
      chk("dmem_be", {28'd0, be}, {28'd0, e.be});
      chk("dmem_we", {31'd0, we}, {31'd0, e.we});
      if (e.we) chk("dmem_wdata", w, e.w);
    end
    if (k == K_LOAD) chk("load_data", a, e.a);
    if (k == K_STALL) chk("stall cycles", a, e.a);
  endtask
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      run_len = 0;
      prev_req = 1'b0;
    end else begin
      if (dmem_req_o && !prev_req) observe(K_REQ, dmem_addr_o, dmem_wdata_o, dmem_be_o, dmem_we_o);
      if (load_valid_o) observe(K_LOAD, load_data_o, '0, '0, 1'b0);
      if (access_err_o) observe(K_ERR, '0, '0, '0, 1'b0);
      if (stall_o) run_len++;
      else if (run_len > 0) begin
        observe(K_STALL, 32'(run_len), '0, '0, 1'b0);
        run_len = 0;
      end
      prev_req = dmem_req_o;
    end
  end
  always @(negedge clk) begin
    if (!manual) begin
      dmem_rvalid_i = pend;
      pend = 1'b0;
      dmem_gnt_i = 1'b0;
      if (dmem_req_o) begin
        if (gnt_wait >= 0 && age >= gnt_wait) begin
          dmem_gnt_i = 1'b1;
          pend = !dmem_we_o;
          age = 0;
        end else age++;
      end else age = 0;
    end
  end
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp_wd,
                     input logic [31:0] exp_ld, input int stall, input logic err);
    int n;
    if (stall == 0) push(K_ERR, '0, '0, '0, 1'b0);
    else begin
      push(K_REQ, {a[31:2], 2'b00}, exp_wd, be, we);
      if (err) push(K_ERR, '0, '0, '0, 1'b0);
      else if (!we) push(K_LOAD, exp_ld, '0, '0, 1'b0);
      push(K_STALL, 32'(stall), '0, '0, 1'b0);
    end
    @(negedge clk);
    mem_valid_i = 1'b1; mem_we_i = we; funct3M = f3; addr_i = a; wdata_i = wd; dmem_rdata_i = rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall_o && n < 60);
    chk("stall released", {31'd0, stall_o}, 32'd0);
    mem_valid_i = 1'b0;
  endtask
  task automatic check_reset_outputs();
    chk("rst stall_o", {31'd0, stall_o}, 32'd0);
    chk("rst dmem_req_o", {31'd0, dmem_req_o}, 32'd0);
    chk("rst dmem_we_o", {31'd0, dmem_we_o}, 32'd0);
    chk("rst dmem_addr_o", dmem_addr_o, 32'd0);
    chk("rst dmem_be_o", {28'd0, dmem_be_o}, 32'd0);
    chk("rst dmem_wdata_o", dmem_wdata_o, 32'd0);
    chk("rst load_valid_o", {31'd0, load_valid_o}, 32'd0);
    chk("rst load_data_o", load_data_o, 32'd0);
    chk("rst access_err_o", {31'd0, access_err_o}, 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    run(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 4'b1111, 0, 32'hDEADBEEF, 3, 0);
    run(0, 3'b000, 32'h103, 0, 32'h80FF0000, 4'b1000, 0, 32'hFFFFFF80, 3, 0);
    run(0, 3'b100, 32'h103, 0, 32'h80FF0000, 4'b1000, 0, 32'h00000080, 3, 0);
    run(0, 3'b000, 32'h101, 0, 32'h00007F00, 4'b0010, 0, 32'h0000007F, 3, 0);
    run(0, 3'b001, 32'h102, 0, 32'h80017FFF, 4'b1100, 0, 32'hFFFF8001, 3, 0);
    run(0, 3'b101, 32'h100, 0, 32'h1234F00D, 4'b0011, 0, 32'h0000F00D, 3, 0);
    run(1, 3'b001, 32'h202, 32'h1234ABCD, 0, 4'b1100, 32'hABCDABCD, 0, 2, 0);
    run(1, 3'b000, 32'h101, 32'h000000A5, 0, 4'b0010, 32'hA5A5A5A5, 0, 2, 0);
    run(1, 3'b010, 32'h400, 32'hCAFEBABE, 0, 4'b1111, 32'hCAFEBABE, 0, 2, 0);
    run(0, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0, 0);
    run(0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    run(1, 3'b100, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    run(0, 3'b001, 32'h101, 0, 0, 0, 0, 0, 0, 0);
    run(0, 3'b110, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    gnt_wait = 1;
    run(0, 3'b010, 32'h500, 0, 32'h11223344, 4'b1111, 0, 32'h11223344, 4, 0);
    gnt_wait = -1;
    run(0, 3'b010, 32'h600, 0, 32'h55555555, 4'b1111, 0, 0, 5, 1);
    repeat (2) @(negedge clk);
    chk("data held after timeout", load_data_o, 32'h11223344);
    chk("req dropped after timeout", {31'd0, dmem_req_o}, 32'd0);
    gnt_wait = 0;
    manual = 1'b1;
    pend = 1'b0;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    push(K_REQ, 32'h300, '0, 4'b1111, 1'b0);
    @(negedge clk);
    mem_valid_i = 1'b1; mem_we_i = 1'b0; funct3M = 3'b010; addr_i = 32'h300;
    @(negedge clk);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    mem_valid_i = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rdata_i = 32'h77777777;
    dmem_rvalid_i = 1'b1;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    manual = 1'b0;
    run(0, 3'b010, 32'h700, 0, 32'h0BADF00D, 4'b1111, 0, 32'h0BADF00D, 3, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
